// File: rtl/axi_write_master.sv
// AXI4 write master: pops FIFO entries into one AW + (awlen+1) W beats, then waits for B.
// AW one cycle after accept; W backpressure stalls FIFO pops; one burst outstanding at a time.
module axi_write_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [ID_WIDTH-1:0]     in_id,
  input  logic [1:0]              in_burst,
  input  logic [2:0]              in_size,
  input  logic [7:0]              in_len,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_strb,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    busy,
  output logic                    done,
  output logic                    err_valid,
  output logic [1:0]              err_resp,
  output logic [ID_WIDTH-1:0]     err_id
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state, state_nxt;
  logic       live;
  logic       w_full;
  logic [8:0] loaded, sent;
  logic       in_hs, w_hs, b_hs, b_err;

  assign in_hs = in_valid && in_ready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign b_err = (bresp != 2'b00) || (bid != awid);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // live keeps in_ready low while reset is asserted even though state is IDLE
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = live;
        if (in_valid && live) state_nxt = ADDR;
      end
      ADDR: begin
        awvalid = 1'b1;
        if (awready) state_nxt = DATA;
      end
      DATA: begin
        wvalid   = w_full;
        wlast    = w_full && (sent == {1'b0, awlen});
        in_ready = (loaded <= {1'b0, awlen}) && (!w_full || wready);
        if (w_full && wready && (sent == {1'b0, awlen})) state_nxt = RESP;
      end
      RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live      <= 1'b0;
      awaddr    <= '0;
      awid      <= '0;
      awlen     <= '0;
      awsize    <= '0;
      awburst   <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      w_full    <= 1'b0;
      loaded    <= '0;
      sent      <= '0;
      done      <= 1'b0;
      err_valid <= 1'b0;
      err_resp  <= '0;
      err_id    <= '0;
    end else begin
      live      <= 1'b1;
      done      <= b_hs;
      err_valid <= b_hs && b_err;
      if (b_hs && b_err) begin
        err_resp <= bresp;
        err_id   <= bid;
      end
      if (state == IDLE) begin
        if (in_hs) begin
          awaddr  <= in_addr;
          awid    <= in_id;
          awlen   <= in_len;
          awsize  <= in_size;
          awburst <= in_burst;
          wdata   <= in_data;
          wstrb   <= in_strb;
          w_full  <= 1'b1;
          loaded  <= 9'd1;
          sent    <= 9'd0;
        end
      end else if (state == DATA) begin
        if (w_hs) sent <= sent + 9'd1;
        // refill on the same edge the held beat drains keeps beats back-to-back
        if (in_hs) begin
          wdata  <= in_data;
          wstrb  <= in_strb;
          w_full <= 1'b1;
          loaded <= loaded + 9'd1;
        end else if (w_hs) begin
          w_full <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_write_master.sv
// Scoreboard bench for axi_write_master: FIFO driver, AXI slave responder, negedge monitor.
module tb_axi_write_master;
  localparam int AW = 32, DW = 64, IW = 4, SW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready;
  logic [AW-1:0] in_addr;
  logic [IW-1:0] in_id;
  logic [1:0]    in_burst;
  logic [2:0]    in_size;
  logic [7:0]    in_len;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_strb;
  logic [AW-1:0] awaddr;
  logic [IW-1:0] awid;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wlast, wvalid;
  logic          wready = 1'b1;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic          busy, done, err_valid;
  logic [1:0]    err_resp;
  logic [IW-1:0] err_id;

  always #5 clk = ~clk;

  axi_write_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_id(in_id),
    .in_burst(in_burst), .in_size(in_size), .in_len(in_len), .in_data(in_data), .in_strb(in_strb),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .busy(busy), .done(done), .err_valid(err_valid), .err_resp(err_resp), .err_id(err_id)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {last, strb, data}, {addr, id, len}, {err, resp, id}
  logic [DW+SW:0]    exp_w[$];
  logic [AW+IW+7:0]  exp_aw[$];
  logic [IW+2:0]     exp_b[$];

  int w_cnt = 0, wlast_cnt = 0, done_cnt = 0, bubble_cnt = 0;
  logic          w_stall = 1'b0, prev_done = 1'b0;
  logic [DW-1:0] held_d;
  logic [1:0]    rsp_resp = 2'b00;
  logic [IW-1:0] rsp_id = '0;
  logic          wmode = 1'b0;

  always @(posedge clk) wready <= wmode ? ~wready : 1'b1;

  always @(negedge clk) begin : monitor
    logic [DW+SW:0]   ew;
    logic [AW+IW+7:0] ea;
    logic [IW+2:0]    eb;
    if (!rst_n) begin
      w_stall   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (w_stall) begin
        check("w_hold_valid", 64'(wvalid), 64'd1);
        check("w_hold_data", wdata, held_d);
      end
      w_stall = wvalid && !wready;
      held_d  = wdata;
      if (busy && !awvalid && !wvalid && !bready) bubble_cnt++;
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
        else begin
          ea = exp_aw.pop_front();
          check("aw_addr", 64'(awaddr), 64'(ea[AW+IW+7:IW+8]));
          check("aw_id", 64'(awid), 64'(ea[IW+7:8]));
          check("aw_len", 64'(awlen), 64'(ea[7:0]));
          check("aw_size_burst", 64'({awsize, awburst}), 64'({3'd3, 2'd1}));
        end
      end
      if (wvalid && wready) begin
        w_cnt++;
        if (wlast) wlast_cnt++;
        if (exp_w.size() == 0) check("w_unexpected", 64'd1, 64'd0);
        else begin
          ew = exp_w.pop_front();
          check("w_data", wdata, ew[DW-1:0]);
          check("w_strb", 64'(wstrb), 64'(ew[DW+SW-1:DW]));
          check("w_last", 64'(wlast), 64'(ew[DW+SW]));
        end
      end
      if (prev_done) check("done_pulse_width", 64'(done), 64'd0);
      prev_done = done;
      if (err_valid && !done) check("err_without_done", 64'd1, 64'd0);
      if (done) begin
        done_cnt++;
        check("in_ready_at_done", 64'(in_ready), 64'd1);
        if (exp_b.size() == 0) check("done_unexpected", 64'd1, 64'd0);
        else begin
          eb = exp_b.pop_front();
          check("err_valid", 64'(err_valid), 64'(eb[IW+2]));
          if (eb[IW+2]) begin
            check("err_resp", 64'(err_resp), 64'(eb[IW+1:IW]));
            check("err_id", 64'(err_id), 64'(eb[IW-1:0]));
          end
        end
      end
    end
  end

  initial begin : responder
    int t;
    bvalid = 1'b0;
    bresp  = 2'b00;
    bid    = '0;
    forever begin
      @(negedge clk);
      if (rst_n && wvalid && wready && wlast) begin
        @(posedge clk);
        #1;
        bvalid = 1'b1;
        bresp  = rsp_resp;
        bid    = rsp_id;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!bready && t < 100);
        @(posedge clk);
        #1;
        bvalid = 1'b0;
      end
    end
  end

  task automatic set_rsp(input logic [1:0] resp, input logic [IW-1:0] id, input logic [IW-1:0] burst_id);
    rsp_resp = resp;
    rsp_id   = id;
    exp_b.push_back({(resp != 2'b00) || (id != burst_id), resp, id});
  endtask

  // non-first entries carry junk headers, which the DUT must ignore
  task automatic feed(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len,
                      input logic [DW-1:0] base, input int n_ent, input int gap_at, input int gap_len);
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    int t;
    exp_aw.push_back({addr, id, len});
    for (int b = 0; b < n_ent; b++) begin
      d = base + DW'(b);
      s = 8'hFF ^ b[7:0];
      if (b == gap_at) begin
        in_valid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      in_strb  = s;
      in_addr  = (b == 0) ? addr : ~addr;
      in_id    = (b == 0) ? id : ~id;
      in_len   = (b == 0) ? len : ~len;
      exp_w.push_back({(b == int'(len)), s, d});
      t = 0;
      while (!in_ready && t < 2000) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start, t;
    start = done_cnt;
    t = 0;
    while (done_cnt == start && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("done_seen", 64'(done_cnt != start), 64'd1);
  endtask

  initial begin : main
    int wb, lb, bb, t;
    in_valid = 1'b0; in_addr = '0; in_id = '0; in_burst = 2'd1; in_size = 3'd3;
    in_len = '0; in_data = '0; in_strb = '0; awready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_valids", 64'({awvalid, wvalid, wlast, bready}), 64'd0);
    check("rst_status", 64'({busy, done, err_valid}), 64'd0);
    check("rst_err_regs", 64'({err_resp, err_id}), 64'd0);
    check("rst_payload", 64'(awaddr) | wdata, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single beat: AW at N+1, W at N+2
    set_rsp(2'b00, 4'd3, 4'd3);
    feed(32'h1000, 4'd3, 8'd0, 64'hDEADBEEF, 1, -1, 0);
    check("t1_awvalid_n1", 64'({awvalid, in_ready}), 64'b10);
    @(posedge clk);
    #1;
    check("t1_wvalid_wlast_n2", 64'({wvalid, wlast}), 64'b11);
    wait_done(50);

    // 4-beat burst with wready toggling
    wb = w_cnt; lb = wlast_cnt;
    wmode = 1'b1;
    set_rsp(2'b00, 4'd1, 4'd1);
    feed(32'h2000, 4'd1, 8'd3, 64'd0, 4, -1, 0);
    check("t2_in_ready_low", 64'(in_ready), 64'd0);
    wait_done(100);
    wmode = 1'b0;
    check("t2_beats", 64'(w_cnt - wb), 64'd4);
    check("t2_wlast_count", 64'(wlast_cnt - lb), 64'd1);

    // FIFO starvation mid-burst
    wb = w_cnt; lb = wlast_cnt; bb = bubble_cnt;
    set_rsp(2'b00, 4'd2, 4'd2);
    feed(32'h3000, 4'd2, 8'd2, 64'h100, 3, 2, 3);
    wait_done(100);
    check("t3_beats", 64'(w_cnt - wb), 64'd3);
    check("t3_wlast_count", 64'(wlast_cnt - lb), 64'd1);
    check("t3_bubble_seen", 64'(bubble_cnt > bb), 64'd1);

    // error responses: SLVERR, then id mismatch
    set_rsp(2'b10, 4'd3, 4'd3);
    feed(32'h4000, 4'd3, 8'd0, 64'h44, 1, -1, 0);
    wait_done(50);
    set_rsp(2'b00, 4'd5, 4'd4);
    feed(32'h5000, 4'd4, 8'd0, 64'h55, 1, -1, 0);
    wait_done(50);
    check("t4_err_id_held", 64'({err_resp, err_id}), 64'({2'b00, 4'd5}));

    // max length
    wb = w_cnt; lb = wlast_cnt;
    set_rsp(2'b00, 4'd6, 4'd6);
    feed(32'h6000, 4'd6, 8'd255, 64'h1000, 256, -1, 0);
    wait_done(2000);
    check("t5_beats", 64'(w_cnt - wb), 64'd256);
    check("t5_wlast_count", 64'(wlast_cnt - lb), 64'd1);
    check("t5_err_held", 64'({err_resp, err_id}), 64'({2'b00, 4'd5}));

    // reset mid-burst after two beats of a 4-beat burst
    wb = w_cnt;
    feed(32'h7000, 4'd7, 8'd3, 64'h70, 2, -1, 0);
    t = 0;
    while (w_cnt - wb < 2 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("t6_two_beats", 64'(w_cnt - wb), 64'd2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready_valid", 64'({in_ready, awvalid, wvalid, wlast, bready}), 64'd0);
    check("t6_rst_status", 64'({busy, done, err_valid, err_resp, err_id}), 64'd0);
    exp_w.delete();
    exp_aw.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_rsp(2'b00, 4'd8, 4'd8);
    feed(32'h8000, 4'd8, 8'd0, 64'h88, 1, -1, 0);
    wait_done(50);

    check("queues_drained", 64'(exp_w.size() + exp_aw.size() + exp_b.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
